branch_resolve_unit: RTL and testbench
======================================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand, PC and immediate width.
REQ-002 SHALL have parameter BR_BIT, default 3: branch-select width; the encodings are the shared `ENUM_BR_*` constants.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: the request is valid.
REQ-006 SHALL have port in_ready, output, 1: the unit accepts a request.
REQ-007 SHALL have ports A and B, input, XLEN each: comparison operands.
REQ-008 SHALL have port BrSel, input, BR_BIT: condition select, one of EQ/NEQ/LT/GTE/LTU/GTEU; any other code means never taken.
REQ-009 SHALL have ports pc and imm, input, XLEN each: branch PC and sign-extended offset.
REQ-010 SHALL have ports pred_taken (input, 1) and pred_target (input, XLEN): the front-end prediction.
REQ-011 SHALL have port flush, input, 1: discard the in-flight result.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-013 SHALL have output ports BrJp (1), mispredict (1) and redirect_pc (XLEN).

Function
REQ-014 SHALL evaluate the conditions as follows: EQ is A==B; NEQ is its inverse; LT is a signed A<B computed on an XLEN+1-bit sign-extended difference; GTE is !LT; LTU is unsigned A<B; GTEU is !LTU.
REQ-015 SHALL compute target = pc+imm and fallthrough = pc+4, both modulo 2^XLEN, with overflow discarded.
REQ-016 SHALL assert mispredict when BrJp != pred_taken, or when BrJp=1, pred_taken=1 and target != pred_target.
REQ-017 SHALL set redirect_pc to target when BrJp=1 and to fallthrough otherwise.
REQ-018 SHALL drive in_ready = !out_valid || out_ready, purely combinationally, with no dependence on in_valid.
REQ-019 SHALL accept a request when in_valid && in_ready; BrJp, mispredict and redirect_pc register on that edge and out_valid=1 from the next cycle (latency 1).
REQ-020 SHALL hold the output registers stable while out_valid && !out_ready.
REQ-021 SHALL, on simultaneous output handshake and new accept, load the new result with out_valid remaining 1, giving full throughput of one per cycle.
REQ-022 SHALL, on an output handshake with no accept, clear out_valid on the next edge.
REQ-023 SHALL, when flush=1, clear out_valid on the next edge and reject any same-cycle input; flush has priority over every other event.
REQ-024 SHALL keep BrJp, mispredict and redirect_pc at their last values when out_valid=0; they are don't-care for the consumer.

Reset
REQ-025 SHALL, while rst=1 (asynchronously), force out_valid=0, BrJp=0, mispredict=0 and redirect_pc=0.
REQ-026 SHALL discard an in-flight result on reset mid-operation; in_ready=1 from the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when macro BRU_STATS_EN is defined, add outputs stat_branches (32) and stat_mispredicts (32), reset to 0 and saturating at 0xFFFFFFFF.
REQ-028 SHALL increment stat_branches on each output handshake whose BrSel was a valid code, and stat_mispredicts when that handshake also carries mispredict=1.
REQ-029 SHALL, when BRU_STATS_EN is undefined, contain no counters and no stat ports.

Verification
REQ-030 SHALL cover: BLT with A=0xFFFFFFFF, B=1, pred_taken=0, pc=0x80000000, imm=0x10 -> next cycle out_valid=1, BrJp=1, mispredict=1, redirect_pc=0x80000010.
REQ-031 SHALL cover: BLTU with A=0xFFFFFFFF, B=1, pred_taken=0, pc=0x100 -> BrJp=0, mispredict=0, redirect_pc=0x104.
REQ-032 SHALL cover: BEQ with A=B=5, pred_taken=1, pred_target=0x200, pc=0x100, imm=0x80 -> BrJp=1, mispredict=1 due to wrong target, redirect_pc=0x180.
REQ-033 SHALL cover: out_ready held 0 for 3 cycles -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> back-to-back results with no bubble.
REQ-034 SHALL cover: flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, and the request is not accepted.
REQ-035 SHALL cover: pc=0xFFFFFFFC, imm=8, BGEU with A=B -> redirect_pc=0x00000004; with BRU_STATS_EN defined, counters preloaded to saturation stay at 0xFFFFFFFF.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves a conditional branch one cycle after it is accepted: evaluates
//   the BrSel condition on A/B, computes the taken target (pc+imm) and the
//   fallthrough (pc+4), and flags a mispredict against the front-end
//   prediction. Results leave through a valid/ready handshake at full
//   throughput.
//
// Parameters
//   XLEN   : operand / PC / immediate width (default 32)
//   BR_BIT : width of BrSel (default 3), codes are the ENUM_BR_* constants
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid / in_ready      : request handshake (in_ready = !out_valid || out_ready)
//   A, B, BrSel              : comparison operands and condition select
//   pc, imm                  : branch PC and sign-extended offset
//   pred_taken, pred_target  : front-end prediction
//   flush                    : drop the in-flight result and any same-cycle request
//   out_valid / out_ready    : result handshake
//   BrJp, mispredict         : resolved direction, prediction was wrong
//   redirect_pc              : target if taken, else fallthrough
//   stat_branches,
//   stat_mispredicts         : saturating counters, only with BRU_STATS_EN
//
// Build option
//   BRU_STATS_EN : adds the statistics counters and their output ports.

`ifndef ENUM_BR_EQ
`define ENUM_BR_EQ   0
`endif
`ifndef ENUM_BR_NEQ
`define ENUM_BR_NEQ  1
`endif
`ifndef ENUM_BR_LT
`define ENUM_BR_LT   2
`endif
`ifndef ENUM_BR_GTE
`define ENUM_BR_GTE  3
`endif
`ifndef ENUM_BR_LTU
`define ENUM_BR_LTU  4
`endif
`ifndef ENUM_BR_GTEU
`define ENUM_BR_GTEU 5
`endif

module branch_resolve_unit #(
    parameter int XLEN   = 32,
    parameter int BR_BIT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   A,
    input  logic [XLEN-1:0]   B,
    input  logic [BR_BIT-1:0] BrSel,
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   imm,
    input  logic              pred_taken,
    input  logic [XLEN-1:0]   pred_target,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              BrJp,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispredicts
`endif
);

    logic [XLEN:0]   diff;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic            taken;
    logic            sel_valid;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthrough;
    logic            mis;
    logic            accept;
    logic            out_fire;

    // Signed compare on a sign-extended XLEN+1 difference cannot overflow;
    // its low XLEN bits are zero exactly when A == B.
    assign diff = {A[XLEN-1], A} - {B[XLEN-1], B};
    assign eq   = ~|diff[XLEN-1:0];
    assign lt   = diff[XLEN];
    assign ltu  = A < B;

    always_comb begin
        taken     = 1'b0;
        sel_valid = 1'b1;
        case (BrSel)
            BR_BIT'(`ENUM_BR_EQ):   taken = eq;
            BR_BIT'(`ENUM_BR_NEQ):  taken = ~eq;
            BR_BIT'(`ENUM_BR_LT):   taken = lt;
            BR_BIT'(`ENUM_BR_GTE):  taken = ~lt;
            BR_BIT'(`ENUM_BR_LTU):  taken = ltu;
            BR_BIT'(`ENUM_BR_GTEU): taken = ~ltu;
            default:                sel_valid = 1'b0;
        endcase
    end

    assign target      = pc + imm;
    assign fallthrough = pc + XLEN'(4);
    assign mis         = (taken != pred_taken) ||
                         (taken && pred_taken && (target != pred_target));

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign out_fire = out_valid && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            BrJp        <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            BrJp        <= taken;
            mispredict  <= mis;
            redirect_pc <= taken ? target : fallthrough;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

`ifdef BRU_STATS_EN
    // Remembers whether the held result came from a valid condition code.
    logic res_sel_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_sel_valid    <= 1'b0;
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accept) begin
                res_sel_valid <= sel_valid;
            end
            if (out_fire && res_sel_valid) begin
                if (stat_branches != '1) begin
                    stat_branches <= stat_branches + 32'd1;
                end
                if (mispredict && (stat_mispredicts != '1)) begin
                    stat_mispredicts <= stat_mispredicts + 32'd1;
                end
            end
        end
    end
`else
    // Statistics disabled: the condition-code validity is not needed.
    logic unused_sel_valid;
    assign unused_sel_valid = sel_valid;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit
//   Self-checking bench for branch_resolve_unit: a table of directed vectors,
//   hand-written stall / flush / reset sequences and a randomized run, all
//   compared against a behavioural model of the branch rules.

module tb_branch_resolve_unit;

    localparam logic [2:0] S_EQ = 3'd0, S_NEQ = 3'd1, S_LT = 3'd2,
                           S_GTE = 3'd3, S_LTU = 3'd4, S_GTEU = 3'd5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B, pc, imm, pred_target;
    logic [2:0]  BrSel;
    logic        pred_taken;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        BrJp;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BRU_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.XLEN(32), .BR_BIT(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .BrSel(BrSel), .pc(pc), .imm(imm),
        .pred_taken(pred_taken), .pred_target(pred_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .BrJp(BrJp),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BRU_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    int nchk = 0;
    int nfail = 0;

    // Model state: the result the consumer should currently see.
    bit          m_valid;
    bit          m_brjp;
    bit          m_mis;
    logic [31:0] m_rp;
    bit          m_selv;
    longint      m_br;
    longint      m_mp;

    typedef struct {
        logic [2:0]  sel;
        logic [31:0] a, b, pc, imm;
        logic        pt;
        logic [31:0] ptgt;
        logic        e_brjp, e_mis;
        logic [31:0] e_rp;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void ref_eval(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] p, input logic [31:0] im, input logic pt,
                                     input logic [31:0] ptgt, output bit brjp, output bit mis,
                                     output logic [31:0] rp);
        logic [31:0] tgt;
        case (sel)
            S_EQ:    brjp = (a == b);
            S_NEQ:   brjp = (a != b);
            S_LT:    brjp = ($signed(a) < $signed(b));
            S_GTE:   brjp = ($signed(a) >= $signed(b));
            S_LTU:   brjp = (a < b);
            S_GTEU:  brjp = (a >= b);
            default: brjp = 1'b0;
        endcase
        tgt = p + im;
        mis = (brjp != pt) || (brjp && pt && tgt != ptgt);
        rp  = brjp ? tgt : p + 32'd4;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_brjp = 0; m_mis = 0; m_rp = '0; m_selv = 0;
        m_br = 0; m_mp = 0;
    endtask

    // One clock with the current inputs: checks in_ready before the edge,
    // advances the model on the edge and checks the registered outputs after.
    task automatic cycle();
        bit          exp_ready, acc, hs, eb, em;
        logic [31:0] er;
        #1;
        exp_ready = !m_valid || out_ready;
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        acc = in_valid && exp_ready && !flush;
        hs  = m_valid && out_ready && !flush;
        ref_eval(BrSel, A, B, pc, imm, pred_taken, pred_target, eb, em, er);
        @(posedge clk);
        if (hs && m_selv) begin
            if (m_br < 64'hFFFFFFFF) m_br++;
            if (m_mis && m_mp < 64'hFFFFFFFF) m_mp++;
        end
        if (flush) m_valid = 0;
        else if (acc) begin
            m_valid = 1; m_brjp = eb; m_mis = em; m_rp = er; m_selv = (BrSel <= S_GTEU);
        end else if (hs) m_valid = 0;
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("BrJp", {31'd0, BrJp}, {31'd0, m_brjp});
        check("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
        check("redirect_pc", redirect_pc, m_rp);
    endtask

    task automatic set_vec(input int i);
        BrSel = vecs[i].sel; A = vecs[i].a; B = vecs[i].b; pc = vecs[i].pc;
        imm = vecs[i].imm; pred_taken = vecs[i].pt; pred_target = vecs[i].ptgt;
    endtask

    task automatic check_vec(input int i);
        check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
        check($sformatf("vec%0d_brjp", i), {31'd0, BrJp}, {31'd0, vecs[i].e_brjp});
        check($sformatf("vec%0d_mis", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mis});
        check($sformatf("vec%0d_rp", i), redirect_pc, vecs[i].e_rp);
    endtask

    initial begin
        //           sel     a             b             pc            imm           pt  ptgt          brjp mis rp
        vecs[0] = '{S_LT,   32'hFFFFFFFF, 32'h1,        32'h80000000, 32'h10,       0, 32'h0,        1, 1, 32'h80000010};
        vecs[1] = '{S_LTU,  32'hFFFFFFFF, 32'h1,        32'h100,      32'h10,       0, 32'h0,        0, 0, 32'h104};
        vecs[2] = '{S_EQ,   32'h5,        32'h5,        32'h100,      32'h80,       1, 32'h200,      1, 1, 32'h180};
        vecs[3] = '{S_GTEU, 32'h7,        32'h7,        32'hFFFFFFFC, 32'h8,        1, 32'h4,        1, 0, 32'h4};
        vecs[4] = '{S_NEQ,  32'h3,        32'h4,        32'h1000,     32'hFFFFFFF0, 1, 32'hFF0,      1, 0, 32'hFF0};
        vecs[5] = '{S_GTE,  32'h80000000, 32'h7FFFFFFF, 32'h2000,     32'h40,       1, 32'h2040,     0, 1, 32'h2004};
        vecs[6] = '{S_LT,   32'h7FFFFFFF, 32'h80000000, 32'h3000,     32'h40,       0, 32'h0,        0, 0, 32'h3004};
        vecs[7] = '{3'd6,   32'h9,        32'h9,        32'h40,       32'h20,       0, 32'h0,        0, 0, 32'h44};
        vecs[8] = '{3'd7,   32'h9,        32'h9,        32'h50,       32'h20,       1, 32'h70,       0, 1, 32'h54};
        vecs[9] = '{S_GTEU, 32'h1,        32'hFFFFFFFF, 32'hFFFFFFFC, 32'h40,       0, 32'h0,        0, 0, 32'h0};

        rst = 1; in_valid = 0; out_ready = 0; flush = 0;
        A = '0; B = '0; BrSel = '0; pc = '0; imm = '0; pred_taken = 0; pred_target = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_brjp_mis", {30'd0, BrJp, mispredict}, 32'd0);
        rst = 0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table, full throughput.
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            set_vec(i); in_valid = 1;
            cycle();
            check_vec(i);
        end

        // Stall: drain, accept vec0 with out_ready low, hold 3 cycles.
        in_valid = 0; out_ready = 1;
        cycle();
        set_vec(0); in_valid = 1; out_ready = 0;
        cycle();
        check_vec(0);
        set_vec(2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check_vec(0);
        end
        out_ready = 1;
        cycle();
        check_vec(2);
        set_vec(1);
        cycle();
        check_vec(1);

        // Flush with a held result and a same-cycle request.
        set_vec(0); in_valid = 1; out_ready = 1; flush = 1;
        cycle();
        check("flush_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush_not_accepted", redirect_pc, 32'h104);
        flush = 0; in_valid = 0;
        cycle();
        check("flush_stays_idle", {31'd0, out_valid}, 32'd0);

        // Randomized run against the model.
        for (int n = 0; n < 400; n++) begin
            A           = $urandom;
            B           = ($urandom_range(0, 3) == 0) ? A : $urandom;
            BrSel       = 3'($urandom_range(0, 7));
            pc          = $urandom;
            imm         = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255));
            pred_taken  = 1'($urandom_range(0, 1));
            pred_target = ($urandom_range(0, 1) == 1) ? pc + imm : $urandom;
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 19) == 0);
            cycle();
        end
        flush = 0;

        // Reset in the middle of an operation.
        set_vec(0); in_valid = 1; out_ready = 0;
        cycle();
        check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
`ifdef BRU_STATS_EN
        check("stat_branches", stat_branches, m_br[31:0]);
        check("stat_mispredicts", stat_mispredicts, m_mp[31:0]);
`endif
        #2 rst = 1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_redirect_pc", redirect_pc, 32'd0);
        check("midrst_brjp_mis", {30'd0, BrJp, mispredict}, 32'd0);
        model_reset();
        in_valid = 0;
        @(posedge clk);
        #1 rst = 0;
        #1;
        check("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        set_vec(3); in_valid = 1;
        cycle();
        check_vec(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
